fetch_stage: RTL

Instruction-fetch stage and IF/ID pipeline register for the pipelined 64-bit LEGv8 CPU. It sits directly upstream of the decode/control block. It owns the PC, drives the instruction-memory address and latches the fetched instruction and its PC into IF/ID. It takes BrTaken/UnConBr back from the control block in ID to redirect the PC, using a one-instruction branch delay slot.

---
 rtl/fetch_stage.sv | 75 +++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the pipelined
// 64-bit LEGv8 core. Owns the PC, presents it to a zero-latency instruction
// memory, and latches the fetched word and its PC into IF/ID. Branches are
// resolved in ID one cycle later, so the instruction fetched alongside a
// taken branch always executes (single delay slot, never flushed).
module fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        BrTaken,
    input  logic        UnConBr,
    input  logic [31:0] imem_data,
    output logic [63:0] imem_addr,
    output logic [31:0] instr_ID,
    output logic [63:0] pc_ID,
    output logic        valid_ID
);

    logic [63:0] pc_reg;
    logic [63:0] pc_next;
    logic [31:0] instr_id_reg;
    logic [63:0] pc_id_reg;
    logic        valid_id_reg;

    logic [63:0] offset_imm26;
    logic [63:0] offset_imm19;
    logic [63:0] branch_offset;
    logic [63:0] branch_target;
    logic        redirect;

    // Sign-extended word offsets for B (Imm26) and CBZ/B.cond (Imm19).
    assign offset_imm26 = {{38{instr_id_reg[25]}}, instr_id_reg[25:0]};
    assign offset_imm19 = {{45{instr_id_reg[23]}}, instr_id_reg[23:5]};

    // Only a real instruction in ID may redirect; a reset bubble forces 0
    // here even if the control block drives garbage on BrTaken.
    assign redirect = valid_id_reg & BrTaken;

    // Branch target and next-PC selection; adds wrap modulo 2^64.
    always_comb begin
        branch_offset = offset_imm19;
        if (UnConBr) begin
            branch_offset = offset_imm26;
        end
        branch_target = pc_id_reg + (branch_offset << 2);
        pc_next       = pc_reg + 64'd4;
        if (redirect) begin
            pc_next = branch_target;
        end
    end

    // PC and IF/ID register: async clear, hold on stall, advance otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg       <= RESET_PC;
            instr_id_reg <= NOP_INSTR;
            pc_id_reg    <= 64'h0;
            valid_id_reg <= 1'b0;
        end else if (!stall) begin
            pc_reg       <= pc_next;
            instr_id_reg <= imem_data;
            pc_id_reg    <= pc_reg;
            valid_id_reg <= 1'b1;
        end
    end

    assign imem_addr = pc_reg;
    assign instr_ID  = instr_id_reg;
    assign pc_ID     = pc_id_reg;
    assign valid_ID  = valid_id_reg;

endmodule
